// File: rtl/rpm_pkg.sv
// ============================================================================
// Module  : rpm_pkg
// Purpose : Shared constants and FSM encoding for the RPM pulse generator
//           and its window timer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rpm_pkg;

    localparam int C      = 50000000;
    localparam int K      = 5;
    localparam int AW     = 26;
    localparam int RATE_W = 8;
    localparam int CNT_W  = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rpm_pulse_gen_if.sv
// ============================================================================
// Module  : rpm_pulse_gen_if
// Purpose : Rate control and pulse-train outputs of the RPM pulse generator.
//           pulse_count exists only with RPM_GEN_PULSE_CNT_EN defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rpm_pulse_gen_if;
    import rpm_pkg::*;

    logic [RATE_W-1:0] rate_in;
    logic              rate_load;
    logic              pulse;
    logic              window_tick;
    logic              overrun;
`ifdef RPM_GEN_PULSE_CNT_EN
    logic [CNT_W-1:0]  pulse_count;

    modport master (output rate_in, rate_load,
                    input  pulse, window_tick, overrun, pulse_count);
    modport slave  (input  rate_in, rate_load,
                    output pulse, window_tick, overrun, pulse_count);
`else
    modport master (output rate_in, rate_load,
                    input  pulse, window_tick, overrun);
    modport slave  (input  rate_in, rate_load,
                    output pulse, window_tick, overrun);
`endif

endinterface

`default_nettype wire

// File: rtl/rpm_window_timer.sv
// ============================================================================
// Module  : rpm_window_timer
// Purpose : Free-running 0..C-1 window counter with a one-cycle tick on the
//           first clock of every window.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rpm_window_timer #(
    parameter int C  = 50000000,
    parameter int AW = 26
) (
    input  logic clk,
    input  logic reset,
    output logic win_last,
    output logic window_tick
);

    logic [AW-1:0] win;

    assign win_last = (win == AW'(C - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win         <= '0;
            window_tick <= 1'b0;
        end else begin
            window_tick <= win_last;
            win         <= win_last ? '0 : win + AW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rpm_pulse_gen.sv
// ============================================================================
// Module  : rpm_pulse_gen
// Purpose : Synthetic active-low coil pulse train, (rate << K) pulses per
//           window of C clocks. Optional RPM_GEN_PULSE_CNT_EN adds pulse_count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rpm_pulse_gen #(
    parameter int C  = rpm_pkg::C,
    parameter int K  = rpm_pkg::K,
    parameter int PW = 1000,
    parameter int AW = rpm_pkg::AW
) (
    input  logic           clk,
    input  logic           reset,
    rpm_pulse_gen_if.slave bus
);
    import rpm_pkg::RATE_W;
    import rpm_pkg::state_t;
    import rpm_pkg::IDLE;
    import rpm_pkg::LOW;
    import rpm_pkg::GAP;

    localparam int          CW    = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [AW:0] C_EXT = (AW + 1)'(C);

    logic              win_last;
    logic              window_tick;
    logic [RATE_W-1:0] shadow;
    logic [RATE_W-1:0] active;
    logic [AW-1:0]     acc;
    logic [AW:0]       sum;
    logic              event_hit;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              pulse_q, pulse_nx;
    logic              pend, pend_nx;
    logic              overrun_q, overrun_nx;
    logic              issue;

    rpm_window_timer #(
        .C  (C),
        .AW (AW)
    ) u_window_timer (
        .clk         (clk),
        .reset       (reset),
        .win_last    (win_last),
        .window_tick (window_tick)
    );

    assign sum       = {1'b0, acc} + (AW + 1)'({active, {K{1'b0}}});
    assign event_hit = (sum >= C_EXT);

    // Rate changes land only at the window boundary, where the phase restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            active <= '0;
            acc    <= '0;
        end else begin
            if (bus.rate_load)
                shadow <= bus.rate_in;
            if (win_last) begin
                active <= shadow;
                acc    <= '0;
            end else begin
                acc <= AW'(event_hit ? sum - C_EXT : sum);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_q   <= 1'b1;
            pend      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pulse_q   <= pulse_nx;
            pend      <= pend_nx;
            overrun_q <= overrun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pulse_nx   = pulse_q;
        pend_nx    = pend;
        overrun_nx = overrun_q;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (event_hit || pend) begin
                    state_nx = LOW;
                    pulse_nx = 1'b0;
                    cnt_nx   = CW'(PW - 1);
                    issue    = 1'b1;
                    // A simultaneous fresh event takes the place of the one served.
                    pend_nx  = pend & event_hit;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    pulse_nx = 1'b1;
                    state_nx = GAP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            GAP:     state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                pulse_nx = 1'b1;
            end
        endcase
        if (state != IDLE && event_hit) begin
            if (pend)
                overrun_nx = 1'b1;
            else
                pend_nx = 1'b1;
        end
    end

    assign bus.pulse       = pulse_q;
    assign bus.overrun     = overrun_q;
    assign bus.window_tick = window_tick;

`ifdef RPM_GEN_PULSE_CNT_EN
    import rpm_pkg::CNT_W;

    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] pulse_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt       <= '0;
            pulse_count_q <= '0;
        end else if (win_last) begin
            pulse_count_q <= win_cnt + CNT_W'(issue);
            win_cnt       <= '0;
        end else begin
            win_cnt <= win_cnt + CNT_W'(issue);
        end
    end

    assign bus.pulse_count = pulse_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rpm_pulse_gen.sv
// ============================================================================
// Module  : tb_rpm_pulse_gen
// Purpose : Timeline model of the pulse generator checked every cycle against
//           two instances (short and long pulse width), plus literal checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rpm_pulse_gen;

    localparam int C    = 10000;
    localparam int K    = 5;
    localparam int AW   = 26;
    localparam int PW_A = 20;
    localparam int PW_B = 400;
    localparam int TMO  = C + 50;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    rpm_pulse_gen_if bus_a ();
    rpm_pulse_gen_if bus_b ();

    rpm_pulse_gen #(.C(C), .K(K), .PW(PW_A), .AW(AW)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a));
    rpm_pulse_gen #(.C(C), .K(K), .PW(PW_B), .AW(AW)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: events come from floor((n+1)*inc/C) steps; pulses are time stamps.
    longint m_cyc[2], m_free[2], m_start[2];
    bit     m_has[2], m_pend[2], m_ovr[2], m_tick[2], m_pulse[2];
    int     m_win[2], m_shadow[2], m_active[2], m_wcnt[2], m_pcnt[2];

    task automatic model_reset(input int i);
        m_cyc[i] = 0;  m_free[i] = 0;   m_start[i] = 0;  m_has[i] = 0;
        m_pend[i] = 0; m_ovr[i] = 0;    m_tick[i] = 0;   m_pulse[i] = 1;
        m_win[i] = 0;  m_shadow[i] = 0; m_active[i] = 0;
        m_wcnt[i] = 0; m_pcnt[i] = 0;
    endtask

    task automatic model_step(input int i, input int pw, input int rin, input bit rl);
        longint inc, w, c;
        bit ev, started;
        inc = longint'(m_active[i]) * (longint'(1) << K);
        w   = longint'(m_win[i]);
        c   = m_cyc[i];
        ev  = (((w + 1) * inc) / C) != ((w * inc) / C);
        started = 0;
        if (c >= m_free[i]) begin
            if (ev || m_pend[i]) begin
                m_start[i] = c + 1;
                m_has[i]   = 1;
                m_free[i]  = c + pw + 2;
                m_pend[i]  = m_pend[i] && ev;
                started    = 1;
            end
        end else if (ev) begin
            if (m_pend[i]) m_ovr[i] = 1;
            else           m_pend[i] = 1;
        end
        m_tick[i] = (m_win[i] == C - 1);
        if (m_tick[i]) begin
            m_pcnt[i]   = m_wcnt[i] + int'(started);
            m_wcnt[i]   = 0;
            m_active[i] = m_shadow[i];
            m_win[i]    = 0;
        end else begin
            m_wcnt[i] = m_wcnt[i] + int'(started);
            m_win[i]  = m_win[i] + 1;
        end
        if (rl) m_shadow[i] = rin;
        m_cyc[i]   = c + 1;
        m_pulse[i] = !(m_has[i] && m_cyc[i] >= m_start[i] && m_cyc[i] < m_start[i] + pw);
    endtask

    always @(posedge clk or negedge reset_a)
        if (!reset_a) model_reset(0);
        else          model_step(0, PW_A, int'(bus_a.rate_in), bus_a.rate_load);

    always @(posedge clk or negedge reset_b)
        if (!reset_b) model_reset(1);
        else          model_step(1, PW_B, int'(bus_b.rate_in), bus_b.rate_load);

    // Per-cycle compare plus per-window falling-edge count of instance A.
    bit     prev_a = 1'b1;
    int     edge_cnt_a = 0, edges_a = 0;
    longint ncyc = 0, tick_cyc = 0, tick_cyc_prev = 0;

    always @(negedge clk) begin
        check("a_pulse",    longint'(bus_a.pulse),       longint'(m_pulse[0]));
        check("a_tick",     longint'(bus_a.window_tick), longint'(m_tick[0]));
        check("a_overrun",  longint'(bus_a.overrun),     longint'(m_ovr[0]));
        check("b_pulse",    longint'(bus_b.pulse),       longint'(m_pulse[1]));
        check("b_tick",     longint'(bus_b.window_tick), longint'(m_tick[1]));
        check("b_overrun",  longint'(bus_b.overrun),     longint'(m_ovr[1]));
`ifdef RPM_GEN_PULSE_CNT_EN
        check("a_pulse_count", longint'(bus_a.pulse_count), longint'(m_pcnt[0]));
        check("b_pulse_count", longint'(bus_b.pulse_count), longint'(m_pcnt[1]));
`endif
        if (prev_a && !bus_a.pulse) edge_cnt_a++;
        prev_a = bus_a.pulse;
        if (bus_a.window_tick) begin
            edges_a       = edge_cnt_a;
            edge_cnt_a    = 0;
            tick_cyc_prev = tick_cyc;
            tick_cyc      = ncyc;
        end
        ncyc++;
    end

    task automatic wait_tick_a(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.window_tick && n < TMO);
        if (!bus_a.window_tick) check({name, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic wait_tick_b(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus_b.window_tick && n < TMO);
        if (!bus_b.window_tick) check({name, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic load_a(input int r);
        bus_a.rate_in   = 8'(r);
        bus_a.rate_load = 1'b1;
        @(negedge clk);
        bus_a.rate_load = 1'b0;
    endtask

    initial begin
        bus_a.rate_in = 8'd0; bus_a.rate_load = 1'b0;
        bus_b.rate_in = 8'd0; bus_b.rate_load = 1'b0;
        fork
            begin : stim_a
                int n;
                bus_a.rate_in   = 8'd3;
                bus_a.rate_load = 1'b1;
                repeat (5) @(negedge clk);
                check("a_rst_pulse",   longint'(bus_a.pulse), 1);
                check("a_rst_tick",    longint'(bus_a.window_tick), 0);
                check("a_rst_overrun", longint'(bus_a.overrun), 0);
                bus_a.rate_load = 1'b0;
                reset_a = 1'b1;

                wait_tick_a("a_t1");
                check("a_win0_edges", edges_a, 0);
                load_a(3);
                wait_tick_a("a_t2");
                check("a_load_in_reset_ignored", edges_a, 0);
                wait_tick_a("a_t3");
                check("a_rate3_edges", edges_a, 96);
                check("a_tick_period", tick_cyc - tick_cyc_prev, C);

                load_a(3);
                repeat (100) @(negedge clk);
                load_a(2);
                wait_tick_a("a_t4");
                check("a_rate3_again_edges", edges_a, 96);
                load_a(0);
                wait_tick_a("a_t5");
                check("a_last_load_wins_edges", edges_a, 64);
                load_a(5);
                wait_tick_a("a_t6");
                check("a_rate0_edges", edges_a, 0);
                check("a_rate0_tick_period", tick_cyc - tick_cyc_prev, C);
                wait_tick_a("a_t7");
                check("a_rate5_edges", edges_a, 160);
`ifdef RPM_GEN_PULSE_CNT_EN
                check("a_pulse_count_160", longint'(bus_a.pulse_count), 160);
`endif
                n = 0;
                while (bus_a.pulse && n < 200) begin @(negedge clk); n++; end
                check("a_found_low_pulse", longint'(bus_a.pulse), 0);
                #2 reset_a = 1'b0;
                #1 check("a_async_reset_pulse", longint'(bus_a.pulse), 1);
                repeat (3) @(negedge clk);
                reset_a = 1'b1;
                repeat (300) @(negedge clk);
                check("a_no_resume_after_reset", longint'(bus_a.pulse), 1);
            end
            begin : stim_b
                repeat (5) @(negedge clk);
                reset_b = 1'b1;
                bus_b.rate_in   = 8'd1;
                bus_b.rate_load = 1'b1;
                @(negedge clk);
                bus_b.rate_load = 1'b0;
                wait_tick_b("b_t1");
                check("b_overrun_at_start", longint'(bus_b.overrun), 0);
                repeat (1874) @(negedge clk);
                check("b_overrun_before_6th_event", longint'(bus_b.overrun), 0);
                @(negedge clk);
                check("b_overrun_after_6th_event", longint'(bus_b.overrun), 1);
                wait_tick_b("b_t2");
                wait_tick_b("b_t3");
                check("b_overrun_sticky", longint'(bus_b.overrun), 1);
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
